tc_hdd_arbiter: RTL and testbench
=================================

Name: tc_hdd_arbiter

Overview:
- Shares one TC_Hdd-style relative-seek storage unit among N requesters that each issue absolute-address word reads and writes.
- Round-robin arbitration picks one request at a time.
- Keeps a shadow copy of the drive head pointer, converts the absolute address into a relative seek, then drives load/save and returns the data.
- Sits between CPU-side ports (program loader, data port) and the single Hdd instance.

Parameters:
- N, 2, number of requesters (2..8).
- ADDR_W, 8, absolute word-address width; requests must address less than MEM_WORDS.
- MEM_WORDS, 256, word count of the attached drive; used only for assertions.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; also wired to the drive's rst so the head pointers stay aligned.
- req_valid  input  N  request pending, one bit per requester.
- req_we  input  N  1 = write, 0 = read.
- req_addr  input  N*ADDR_W  absolute word address; requester i in slice [i*ADDR_W +: ADDR_W].
- req_wdata  input  N*64  write data; requester i in slice [i*64 +: 64].
- req_ready  output  N  one-hot, one-cycle pulse: request accepted.
- resp_valid  output  N  one-hot, one-cycle pulse: request complete.
- resp_rdata  output  64  read data, valid while any resp_valid bit is high.
- hdd_seek  output  64  relative seek to the drive.
- hdd_load  output  1  drive load strobe.
- hdd_save  output  1  drive save strobe.
- hdd_in  output  64  drive write data.
- hdd_out  input  64  drive read data.
- head  output  ADDR_W  shadow head pointer.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: rst is synchronous and active-high, clock is clk.
  - Reset values: state IDLE, head 0, rr_ptr 0, every output 0.
- Reset mid-operation: the operation is abandoned. No resp_valid is produced. The requester must keep req_valid high, and the request is re-arbitrated after reset.
- States: IDLE, SEEK, ACCESS, RESP. All outputs are decoded from registered state (Moore).
- IDLE:
  - Grant goes to the first requester with req_valid set, searching from rr_ptr upward and wrapping at N-1 → 0.
  - Granting pulses req_ready[g] in the same cycle, latches g/we/addr/wdata, and sets rr_ptr to (g+1) mod N.
  - Next state is SEEK if addr != head, otherwise ACCESS.
  - With no request, stay in IDLE.
- SEEK (1 cycle):
  - hdd_seek = zero-extended addr minus zero-extended head, as 64-bit two's complement (backward seeks are negative).
  - head <= addr.
  - Next state: ACCESS.
- ACCESS (1 cycle):
  - hdd_seek = 0.
  - Write: hdd_save = 1 and hdd_in = wdata; the drive writes on the following negedge at the new head.
  - Read: hdd_load = 1; the drive registers mem[head] at the closing posedge.
  - Next state: RESP.
- RESP (1 cycle):
  - resp_valid[g] = 1.
  - resp_rdata = hdd_out for a read, 0 for a write.
  - Next state: IDLE.
- Timing: grant cycle G → resp_valid at G+3 with a seek, G+2 without one.
  - Minimum request spacing is 3 cycles (seek hit) or 4 cycles (seek miss).
- Requests arriving outside IDLE wait; req_* must stay stable until req_ready.
- hdd_load and hdd_save are never both high. hdd_seek is nonzero only in SEEK.
- req_valid deasserted before grant is legal: the request is simply dropped.
- head wraps modulo 2^ADDR_W. The seek delta always uses the full 64-bit subtraction.
- Assertion: req_addr < MEM_WORDS whenever req_valid is high.

Decomposition:
- Package tc_hdd_arb_pkg holds:
  - the state enum (IDLE/SEEK/ACCESS/RESP);
  - the 64-bit word width constant;
  - a function seek_delta(target, head) returning a 64-bit signed difference.
- One sub-module, tc_rr_arbiter: N-bit request vector plus pointer in, one-hot grant and grant index out, purely combinational.
  - The FSM, pointer update and head tracking live in the top level.

Test Plan:
(Every bench instantiates the arbiter with a real TC_Hdd, N=2, MEM_WORDS=256, and checks every hdd_* signal cycle by cycle.)
1. After reset, req0 writes addr 5 with data 0xDEAD → req_ready=01 in cycle G; hdd_seek=5 at G+1; hdd_save=1 with hdd_in=0xDEAD at G+2; resp_valid=01 at G+3; head=5.
2. Next, req1 reads addr 5 → no SEEK; hdd_seek stays 0; hdd_load at G+1; resp_valid=10 with resp_rdata=0xDEAD at G+2.
3. From reset, both requesters hold reads → grant order 0, 1, 0, 1 while both stay valid; rr_ptr alternates; no grant occurs while busy=1.
4. head=200, req0 reads addr 3 → hdd_seek=64'hFFFF_FFFF_FFFF_FF3B (-197); head=3 afterwards; the data returned is the word written earlier at addr 3.
5. rst pulsed during SEEK of a write to addr 9 → all outputs 0 and head=0 next cycle; no resp_valid; the held request is re-granted and completes, and a read of addr 9 then returns that data.
6. req0 write→read back-to-back to addr 255, then a read of addr 0 → seeks of +255, then 0, then -255 (64'hFFFF_FFFF_FFFF_FF01); data integrity holds at both ends of memory.

Source files
------------

// File: rtl/tc_hdd_arb_pkg.sv
// Shared types and helpers for the Hdd arbiter.
//   WORD_W     : data word width of the attached drive (64 bits)
//   state_e    : arbiter FSM states
//   seek_delta : signed relative seek from the current head to a target
package tc_hdd_arb_pkg;

   localparam int WORD_W = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEEK   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   // Operands arrive zero-extended, so a plain 64-bit subtraction yields the
   // two's-complement distance (negative for a backward seek).
   function automatic logic signed [WORD_W-1:0] seek_delta(
      input logic [WORD_W-1:0] target,
      input logic [WORD_W-1:0] cur_head
   );
      return $signed(target - cur_head);
   endfunction

endpackage

// File: rtl/tc_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector, one bit per requester
//   ptr_i : index searched first; search wraps from N-1 back to 0
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : index of the granted requester
//   vld_o : high when any request was granted
module tc_rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             vld_o
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      gnt_o    = '0;
      idx_o    = '0;
      vld_o    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         cand_idx = IDX_W'(cand);
         // First hit in search order wins; later hits are ignored.
         if (!vld_o && req_i[cand_idx]) begin
            gnt_o[cand_idx] = 1'b1;
            idx_o           = cand_idx;
            vld_o           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tc_hdd_arbiter.sv
// Shares one relative-seek Hdd among N absolute-address word requesters.
// A shadow of the drive head converts each absolute address into a seek.
//   clk, rst   : clock, synchronous active-high reset (also resets the drive)
//   req_valid  : request pending per requester
//   req_we     : 1 = write, 0 = read
//   req_addr   : absolute word addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  : write data, requester i at [i*64 +: 64]
//   req_ready  : one-hot accept pulse
//   resp_valid : one-hot completion pulse
//   resp_rdata : read data (0 for writes) while resp_valid is high
//   hdd_seek/hdd_load/hdd_save/hdd_in/hdd_out : drive interface
//   head       : shadow head pointer
//   busy       : arbiter not in IDLE
module tc_hdd_arbiter
   import tc_hdd_arb_pkg::*;
#(
   parameter int N         = 2,
   parameter int ADDR_W    = 8,
   parameter int MEM_WORDS = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req_valid,
   input  logic [N-1:0]          req_we,
   input  logic [N*ADDR_W-1:0]   req_addr,
   input  logic [N*WORD_W-1:0]   req_wdata,
   output logic [N-1:0]          req_ready,
   output logic [N-1:0]          resp_valid,
   output logic [WORD_W-1:0]     resp_rdata,
   output logic [WORD_W-1:0]     hdd_seek,
   output logic                  hdd_load,
   output logic                  hdd_save,
   output logic [WORD_W-1:0]     hdd_in,
   input  logic [WORD_W-1:0]     hdd_out,
   output logic [ADDR_W-1:0]     head,
   output logic                  busy
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W-1:0]  head_q, head_d;
   logic [WORD_W-1:0]  wdata_q, wdata_d;

   logic [ADDR_W-1:0]  addr_arr  [N];
   logic [WORD_W-1:0]  wdata_arr [N];

   logic [N-1:0]       gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_vld;
   logic               grant;

   for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*WORD_W +: WORD_W];
   end

   tc_rr_arbiter #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_rr (
      .req_i (req_valid),
      .ptr_i (rr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .vld_o (gnt_vld)
   );

   // Suppressed while rst is high so every output reads 0 during reset.
   assign grant = (state_q == IDLE) && gnt_vld && !rst;

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gidx_d  = gidx_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      head_d  = head_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               gidx_d  = gnt_idx;
               we_d    = req_we[gnt_idx];
               addr_d  = addr_arr[gnt_idx];
               wdata_d = wdata_arr[gnt_idx];
               rr_d    = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
               // Skip the seek entirely when the head is already in place.
               state_d = (addr_arr[gnt_idx] != head_q) ? SEEK : ACCESS;
            end
         end
         SEEK: begin
            head_d  = addr_q;
            state_d = ACCESS;
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         head_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         head_q  <= head_d;
      end
   end

   // Transaction payload only matters in non-IDLE states, so it needs no reset.
   always_ff @(posedge clk) begin
      gidx_q  <= gidx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

   always_comb begin
      req_ready  = grant ? gnt : '0;
      resp_valid = '0;
      resp_rdata = '0;
      hdd_seek   = '0;
      hdd_load   = 1'b0;
      hdd_save   = 1'b0;
      hdd_in     = '0;
      case (state_q)
         SEEK: hdd_seek = seek_delta(WORD_W'(addr_q), WORD_W'(head_q));
         ACCESS: begin
            if (we_q) begin
               hdd_save = 1'b1;
               hdd_in   = wdata_q;
            end else begin
               hdd_load = 1'b1;
            end
         end
         RESP: begin
            resp_valid[gidx_q] = 1'b1;
            if (!we_q) begin
               resp_rdata = hdd_out;
            end
         end
         default: ;
      endcase
   end

   assign head = head_q;
   assign busy = (state_q != IDLE);

   for (genvar gi = 0; gi < N; gi++) begin : g_addr_chk
      always_ff @(posedge clk) begin
         if (!rst && req_valid[gi]) begin
            assert (32'(addr_arr[gi]) < MEM_WORDS);
         end
      end
   end

endmodule

// File: tb/tb_tc_hdd_arbiter.sv
module tb_tc_hdd_arbiter;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    req_valid = '0;
   logic [1:0]    req_we = '0;
   logic [15:0]   req_addr = '0;
   logic [127:0]  req_wdata = '0;
   logic [1:0]    req_ready;
   logic [1:0]    resp_valid;
   logic [63:0]   resp_rdata;
   logic [63:0]   hdd_seek;
   logic          hdd_load;
   logic          hdd_save;
   logic [63:0]   hdd_in;
   logic [63:0]   hdd_out;
   logic [7:0]    head;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tc_hdd_arbiter #(.N(2), .ADDR_W(8), .MEM_WORDS(256)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .hdd_seek   (hdd_seek),
      .hdd_load   (hdd_load),
      .hdd_save   (hdd_save),
      .hdd_in     (hdd_in),
      .hdd_out    (hdd_out),
      .head       (head),
      .busy       (busy)
   );

   // Relative-seek drive: head moves by the seek at each posedge, loads
   // register mem[head] at the posedge, saves land on the negedge.
   logic [63:0] mem [256];
   logic [7:0]  dhead;
   logic [63:0] dout;
   assign hdd_out = dout;

   always @(posedge clk) begin
      if (rst) begin
         dhead <= '0;
         dout  <= '0;
      end else begin
         dhead <= dhead + hdd_seek[7:0];
         if (hdd_load) dout <= mem[dhead];
      end
   end

   always @(negedge clk) begin
      if (hdd_save) mem[dhead] <= hdd_in;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst = 1'b1;
      nxt();
      nxt();
      #1;
      chk("rst_ready", 64'(req_ready), 0);
      chk("rst_resp", 64'(resp_valid), 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_seek", hdd_seek, 0);
      chk("rst_ldsv", 64'({hdd_load, hdd_save}), 0);
      chk("rst_in", hdd_in, 0);
      chk("rst_head", 64'(head), 0);
      chk("rst_busy", 64'(busy), 0);
      rst = 1'b0;
   endtask

   // One complete transaction from requester i, checked cycle by cycle.
   // exp_seek == 0 means no SEEK cycle is expected.
   task automatic txn(input int i, input logic we, input logic [7:0] addr,
                      input logic [63:0] wd, input logic [63:0] exp_seek,
                      input logic [63:0] exp_rd);
      logic [1:0] oh;
      oh = 2'b01 << i;
      req_valid[i]           = 1'b1;
      req_we[i]              = we;
      req_addr[i*8 +: 8]     = addr;
      req_wdata[i*64 +: 64]  = wd;
      #1;
      chk("grant_ready", 64'(req_ready), 64'(oh));
      chk("grant_busy", 64'(busy), 0);
      nxt();
      req_valid[i] = 1'b0;
      #1;
      if (exp_seek != 0) begin
         chk("seek_val", hdd_seek, exp_seek);
         chk("seek_ldsv", 64'({hdd_load, hdd_save}), 0);
         chk("seek_busy", 64'(busy), 1);
         nxt();
         #1;
      end
      chk("acc_seek", hdd_seek, 0);
      chk("acc_save", 64'(hdd_save), 64'(we));
      chk("acc_load", 64'(hdd_load), 64'(!we));
      chk("acc_in", hdd_in, we ? wd : 64'd0);
      chk("acc_head", 64'(head), 64'(addr));
      nxt();
      #1;
      chk("resp_valid", 64'(resp_valid), 64'(oh));
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_ready", 64'(req_ready), 0);
      nxt();
      #1;
      chk("idle_busy", 64'(busy), 0);
      chk("idle_resp", 64'(resp_valid), 0);
   endtask

   initial begin
      // Reset state
      do_reset();

      // 1: write 0xDEAD to addr 5 (seek +5); 2: read back from req1, no seek
      txn(0, 1'b1, 8'd5, 64'hDEAD, 64'd5, 64'd0);
      chk("t1_head", 64'(head), 5);
      txn(1, 1'b0, 8'd5, 64'd0, 64'd0, 64'hDEAD);

      // 3: both requesters hold reads of addr 0 -> alternate 0,1,0,1
      do_reset();
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr  = '0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
         nxt();
         #1;
         chk("rr_busy_ready", 64'(req_ready), 0);
         chk("rr_busy", 64'(busy), 1);
         chk("rr_load", 64'(hdd_load), 1);
         nxt();
         #1;
         chk("rr_resp", 64'(resp_valid), (k % 2 == 0) ? 64'h1 : 64'h2);
         chk("rr_resp_ready", 64'(req_ready), 0);
         nxt();
      end
      req_valid = '0;
      #1;
      chk("rr_idle_ready", 64'(req_ready), 0);

      // 4: write addr 3, move head to 200, read addr 3 with backward seek
      txn(0, 1'b1, 8'd3, 64'h1234_5678_9ABC_DEF0, 64'd3, 64'd0);
      txn(1, 1'b1, 8'd200, 64'h55, 64'd197, 64'd0);
      chk("t4_head200", 64'(head), 200);
      txn(0, 1'b0, 8'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FF3B, 64'h1234_5678_9ABC_DEF0);
      chk("t4_head3", 64'(head), 3);

      // 5: reset during SEEK of a write to addr 9, request held and re-granted
      req_valid[0]      = 1'b1;
      req_we[0]         = 1'b1;
      req_addr[7:0]     = 8'd9;
      req_wdata[63:0]   = 64'h99;
      #1;
      chk("t5_ready", 64'(req_ready), 1);
      nxt();
      #1;
      chk("t5_seek", hdd_seek, 64'd6);
      rst = 1'b1;
      nxt();
      #1;
      chk("t5_rst_ready", 64'(req_ready), 0);
      chk("t5_rst_resp", 64'(resp_valid), 0);
      chk("t5_rst_seek", hdd_seek, 0);
      chk("t5_rst_ldsv", 64'({hdd_load, hdd_save}), 0);
      chk("t5_rst_in", hdd_in, 0);
      chk("t5_rst_head", 64'(head), 0);
      chk("t5_rst_busy", 64'(busy), 0);
      rst = 1'b0;
      txn(0, 1'b1, 8'd9, 64'h99, 64'd9, 64'd0);
      txn(1, 1'b0, 8'd9, 64'd0, 64'd0, 64'h99);

      // 6: write addr 0 (seek -9), then from reset write/read 255 and read 0
      txn(1, 1'b1, 8'd0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFF7, 64'd0);
      do_reset();
      txn(0, 1'b1, 8'd255, 64'hA5A5_5A5A_F00D_CAFE, 64'd255, 64'd0);
      txn(0, 1'b0, 8'd255, 64'd0, 64'd0, 64'hA5A5_5A5A_F00D_CAFE);
      txn(0, 1'b0, 8'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FF01, 64'h0123_4567_89AB_CDEF);
      chk("t6_head", 64'(head), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
